// File: rtl/daq_event_arbiter_if.sv
// Event-word bus between the per-channel readout FIFOs, the arbiter and the
// transfer block. Every stream uses valid/ready: a word moves on a cycle where valid & ready are both high.
interface daq_event_arbiter_if #(
   parameter int N_CHAN = 4
);
   logic [N_CHAN*32-1:0] chan_data;
   logic [N_CHAN-1:0]    chan_valid;
   logic [N_CHAN-1:0]    chan_last;
   logic [N_CHAN-1:0]    chan_ready;
   logic [31:0]          fifo_data;
   logic                 fifo_valid;
   logic                 fifo_last;
   logic                 fifo_ready;

   modport master (
      input  chan_data, chan_valid, chan_last, fifo_ready,
      output chan_ready, fifo_data, fifo_valid, fifo_last
   );

   modport slave (
      output chan_data, chan_valid, chan_last, fifo_ready,
      input  chan_ready, fifo_data, fifo_valid, fifo_last
   );
endinterface

// File: rtl/daq_event_arbiter.sv
// Round-robin arbiter granting one readout channel per whole event onto the
// transfer block's word handshake, with event/word bookkeeping and over-length flag.
module daq_event_arbiter #(
   parameter int N_CHAN    = 4,
   parameter int CHAN_W    = 2,
   parameter int MAX_WORDS = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_CHAN-1:0] chan_enable,
   daq_event_arbiter_if.master bus,
   output logic [CHAN_W-1:0] grant_chan,
   output logic              busy,
   output logic [23:0]       event_count,
   output logic [15:0]       word_count,
   output logic              err_overlong,
   input  logic              err_clr,
   output logic [1:0]        state_dbg
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_XFER = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   logic [1:0]        state;
   logic [CHAN_W-1:0] last_grant;
   logic [N_CHAN-1:0] req;
   logic [CHAN_W-1:0] winner;
   logic              found;
   int                idx;
   logic              hs;
   logic [16:0]       wc_inc;
   logic              set_err;

   // Scan starts one past the previous winner so every enabled requester is served in turn.
   always_comb begin
      req    = bus.chan_valid & chan_enable;
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = 1; k <= N_CHAN; k++) begin
         idx = (int'(last_grant) + k) % N_CHAN;
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = CHAN_W'(idx);
         end
      end
   end

   always_comb begin
      bus.fifo_data  = '0;
      bus.fifo_valid = 1'b0;
      bus.fifo_last  = 1'b0;
      bus.chan_ready = '0;
      if (state == ST_XFER) begin
         bus.fifo_data              = bus.chan_data[32*grant_chan +: 32];
         bus.fifo_valid             = bus.chan_valid[grant_chan];
         bus.fifo_last              = bus.chan_last[grant_chan];
         bus.chan_ready[grant_chan] = bus.fifo_ready;
      end
   end

   assign hs        = bus.fifo_valid & bus.fifo_ready;
   assign wc_inc    = {1'b0, word_count} + 17'd1;
   assign set_err   = hs && !bus.fifo_last && (word_count != 16'hFFFF) &&
                      (wc_inc == 17'(MAX_WORDS));
   assign busy      = (state == ST_XFER);
   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         grant_chan   <= '0;
         last_grant   <= CHAN_W'(N_CHAN - 1);
         event_count  <= '0;
         word_count   <= '0;
         err_overlong <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (found) begin
                  grant_chan <= winner;
                  last_grant <= winner;
                  word_count <= '0;
                  state      <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (hs) begin
                  if (word_count != 16'hFFFF) word_count <= wc_inc[15:0];
                  if (bus.fifo_last) begin
                     event_count <= event_count + 24'd1;
                     state       <= ST_GAP;
                  end
               end
            end
            ST_GAP:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
         // A new over-length detection outranks a simultaneous clear.
         if (set_err)      err_overlong <= 1'b1;
         else if (err_clr) err_overlong <= 1'b0;
      end
   end
endmodule

// File: tb/tb_daq_event_arbiter.sv
// Directed bench for daq_event_arbiter: channel word sources, a scoreboard of
// expected {channel, last, data} words in grant order, and a bus monitor.
module tb_daq_event_arbiter;
   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [N-1:0] chan_enable = '1;
   logic [1:0]  grant_chan;
   logic        busy;
   logic [23:0] event_count;
   logic [15:0] word_count;
   logic        err_overlong;
   logic        err_clr = 1'b0;
   logic [1:0]  state_dbg;

   daq_event_arbiter_if #(.N_CHAN(N)) bus ();

   daq_event_arbiter #(.N_CHAN(N), .CHAN_W(2), .MAX_WORDS(4)) dut (
      .clk(clk), .rst(rst), .chan_enable(chan_enable), .bus(bus),
      .grant_chan(grant_chan), .busy(busy), .event_count(event_count),
      .word_count(word_count), .err_overlong(err_overlong),
      .err_clr(err_clr), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   logic [32:0] src_q[N][$];
   logic [34:0] exp_q[$];
   logic [N-1:0] stall = '0;
   logic [N-1:0] acc = '0;
   bit tog_en = 0;
   bit watch_13 = 0;
   int bad_13 = 0;
   int bad_onehot = 0;
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void drive();
      for (int c = 0; c < N; c++) begin
         if (src_q[c].size() > 0 && !stall[c]) begin
            bus.chan_valid[c]         = 1'b1;
            bus.chan_data[32*c +: 32] = src_q[c][0][31:0];
            bus.chan_last[c]          = src_q[c][0][32];
         end else begin
            bus.chan_valid[c]         = 1'b0;
            bus.chan_data[32*c +: 32] = '0;
            bus.chan_last[c]          = 1'b0;
         end
      end
   endfunction

   task automatic push_event(int c, int n, int tag, bit to_exp);
      logic [32:0] w;
      for (int i = 0; i < n; i++) begin
         w = {(i == n - 1), 32'hC000_0000 | (c << 16) | (tag << 8) | i};
         src_q[c].push_back(w);
         if (to_exp) exp_q.push_back({2'(c), w});
      end
   endtask

   task automatic flush();
      for (int c = 0; c < N; c++) src_q[c].delete();
      exp_q.delete();
      stall = '0;
      drive();
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic wait_done(string name);
      int n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || state_dbg != 2'd0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(n >= 300), 64'd0);
   endtask

   // Sources: consume words the arbiter accepted, then re-present the next word.
   always @(negedge clk) acc = bus.chan_valid & bus.chan_ready;
   always @(posedge clk) begin
      #1;
      for (int c = 0; c < N; c++)
         if (acc[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
      if (tog_en) bus.fifo_ready = ~bus.fifo_ready;
      drive();
   end

   // Monitor: every transferred word must be the next expected one.
   always @(negedge clk) begin
      logic [34:0] e;
      if (!rst) begin
         if ($countones(bus.chan_ready) > 1) bad_onehot++;
         if (watch_13 && (bus.chan_ready[1] || bus.chan_ready[3])) bad_13++;
         if (bus.fifo_valid && bus.fifo_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", {30'd0, grant_chan, bus.fifo_last, bus.fifo_data}, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("word", {29'd0, grant_chan, bus.fifo_last, bus.fifo_data}, {29'd0, e});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.fifo_ready = 1'b1;
      drive();
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      check("rst_state", 64'(state_dbg), 64'd0);
      check("rst_grant", 64'(grant_chan), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_fifo_valid", 64'(bus.fifo_valid), 64'd0);
      check("rst_chan_ready", 64'(bus.chan_ready), 64'd0);
      check("rst_counts", {event_count, word_count, 7'd0, err_overlong}, 64'd0);

      // Single 3-word event on channel 2.
      step();
      push_event(2, 3, 1, 1);
      drive();
      @(negedge clk);
      check("t1_not_yet_granted", 64'(busy), 64'd0);
      @(negedge clk);
      check("t1_grant", 64'(grant_chan), 64'd2);
      check("t1_busy", 64'(busy), 64'd1);
      repeat (3) @(negedge clk);
      check("t1_busy_after_last", 64'(busy), 64'd0);
      check("t1_event_count", 64'(event_count), 64'd1);
      check("t1_word_count", 64'(word_count), 64'd3);
      wait_done("t1_done");

      // All channels valid with 2-word events: grants 0,1,2,3,0 at 4 cycles/event.
      do_reset();
      push_event(0, 2, 2, 1);
      push_event(1, 2, 2, 1);
      push_event(2, 2, 2, 1);
      push_event(3, 2, 2, 1);
      push_event(0, 2, 3, 1);
      drive();
      repeat (19) @(negedge clk);
      check("t2_ec_before_5th", 64'(event_count), 64'd4);
      @(negedge clk);
      check("t2_ec_5th", 64'(event_count), 64'd5);
      wait_done("t2_done");

      // Enable mask 0101: grants alternate 0,2 and channels 1,3 are never served.
      do_reset();
      chan_enable = 4'b0101;
      watch_13 = 1;
      push_event(0, 2, 4, 1);
      push_event(2, 2, 4, 1);
      push_event(0, 2, 5, 1);
      push_event(2, 2, 5, 1);
      push_event(1, 2, 4, 0);
      push_event(3, 2, 4, 0);
      drive();
      wait_done("t3_done");
      repeat (3) @(negedge clk);
      watch_13 = 0;
      check("t3_ready_1_3", 64'(bad_13), 64'd0);
      check("t3_ch1_untouched", 64'(src_q[1].size()), 64'd2);
      check("t3_event_count", 64'(event_count), 64'd4);
      step();
      flush();
      chan_enable = 4'b1111;

      // Channel 1 with back-pressure, a 2-cycle valid gap and enable dropped mid-event.
      do_reset();
      push_event(1, 4, 6, 1);
      drive();
      tog_en = 1;
      repeat (3) step();
      stall[1] = 1'b1;
      chan_enable[1] = 1'b0;
      drive();
      @(negedge clk);
      check("t4_stall_valid", 64'(bus.fifo_valid), 64'd0);
      check("t4_stall_busy", 64'(busy), 64'd1);
      check("t4_stall_grant", 64'(grant_chan), 64'd1);
      step();
      step();
      stall[1] = 1'b0;
      drive();
      wait_done("t4_done");
      tog_en = 0;
      bus.fifo_ready = 1'b1;
      chan_enable = 4'b1111;
      check("t4_event_count", 64'(event_count), 64'd1);
      check("t4_word_count", 64'(word_count), 64'd4);
      check("t4_no_err", 64'(err_overlong), 64'd0);

      // 6-word event against MAX_WORDS=4.
      do_reset();
      push_event(0, 6, 7, 1);
      drive();
      repeat (5) @(negedge clk);
      check("t5_err_before_4th", 64'(err_overlong), 64'd0);
      @(negedge clk);
      check("t5_err_after_4th", 64'(err_overlong), 64'd1);
      wait_done("t5_done");
      check("t5_word_count", 64'(word_count), 64'd6);
      check("t5_event_count", 64'(event_count), 64'd1);
      check("t5_err_sticky", 64'(err_overlong), 64'd1);
      step();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      @(negedge clk);
      check("t5_err_cleared", 64'(err_overlong), 64'd0);

      // Reset in the middle of an event, then 1-word events on every channel.
      step();
      push_event(3, 5, 8, 1);
      drive();
      repeat (3) @(negedge clk);
      check("t6_mid_busy", 64'(busy), 64'd1);
      step();
      flush();
      rst = 1'b1;
      step();
      rst = 1'b0;
      push_event(0, 1, 9, 1);
      push_event(1, 1, 9, 1);
      push_event(2, 1, 9, 1);
      push_event(3, 1, 9, 1);
      drive();
      @(negedge clk);
      check("t6_state", 64'(state_dbg), 64'd0);
      check("t6_outputs", {bus.chan_ready, 26'd0, bus.fifo_valid, bus.fifo_last, busy, grant_chan},
            64'd0);
      check("t6_fifo_data", 64'(bus.fifo_data), 64'd0);
      check("t6_counts", {event_count, word_count, 7'd0, err_overlong}, 64'd0);
      wait_done("t6_done");
      check("t6_event_count", 64'(event_count), 64'd4);
      check("t6_word_count", 64'(word_count), 64'd1);
      check("onehot_ready", 64'(bad_onehot), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
